noise_note_sequencer: RTL and testbench

Pattern sequencer that drives the note-control inputs of the noise channel: note value, length, envelope attack/decay, FX select, note reset pulse and the note clock. It holds a 16-step pattern RAM loaded by the host, plays it at a programmable tempo, and optionally loops. It sits between the host/control logic and `nz_channel`. All timing derives from `clk50mhz`.

---
 rtl/noise_note_sequencer.sv | 137 +++++++++++++
 tb/tb_noise_note_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_note_sequencer.sv
// Step sequencer for the noise channel: plays a host-loaded 16-step pattern RAM
// at a tempo derived from a free-running note_clk divider.
module noise_note_sequencer #(
    parameter int TICK_DIV = 390625
) (
    input  logic        clk50mhz,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    input  logic [3:0]  pattern_len,
    input  logic [2:0]  tempo,
    output logic        note_clk,
    output logic        note_rst,
    output logic [5:0]  note_in,
    output logic [2:0]  note_length,
    output logic [1:0]  env_atk,
    output logic [1:0]  env_dec,
    output logic [1:0]  fx_sel,
    output logic        busy,
    output logic [3:0]  step_idx,
    output logic        done
);
    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, TRIGGER, PLAY} state_t;

    state_t           state_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [2:0]       edge_cnt_reg;
    logic [15:0]      mem [16];
    logic [15:0]      rd_data_reg;
    logic             div_wrap;
    logic             clk_rise;

    assign div_wrap = (div_cnt_reg == DIV_W'(TICK_DIV - 1));
    // High in the cycle whose closing edge takes note_clk from 0 to 1.
    assign clk_rise = div_wrap && !note_clk;

    always_ff @(posedge clk50mhz or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
            note_clk    <= 1'b0;
        end else if (div_wrap) begin
            div_cnt_reg <= '0;
            note_clk    <= ~note_clk;
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

    // Pattern RAM: kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk50mhz) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk50mhz) begin
        if (state_reg == FETCH) begin
            rd_data_reg <= mem[step_idx];
        end
    end

    always_ff @(posedge clk50mhz or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            edge_cnt_reg <= '0;
            step_idx     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            note_rst     <= 1'b0;
            note_in      <= '0;
            note_length  <= '0;
            env_atk      <= '0;
            env_dec      <= '0;
            fx_sel       <= '0;
        end else begin
            note_rst <= 1'b0;
            done     <= 1'b0;
            // stop beats start and any step-end decision; note outputs hold.
            if (stop) begin
                state_reg <= IDLE;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            state_reg <= FETCH;
                            step_idx  <= '0;
                            busy      <= 1'b1;
                        end
                    end
                    FETCH: begin
                        state_reg <= TRIGGER;
                    end
                    TRIGGER: begin
                        note_in      <= rd_data_reg[5:0];
                        note_length  <= rd_data_reg[8:6];
                        fx_sel       <= rd_data_reg[10:9];
                        env_atk      <= rd_data_reg[12:11];
                        env_dec      <= rd_data_reg[14:13];
                        note_rst     <= ~rd_data_reg[15];
                        edge_cnt_reg <= '0;
                        state_reg    <= PLAY;
                    end
                    PLAY: begin
                        if (clk_rise) begin
                            // >= keeps a mid-step tempo decrease from overrunning.
                            if (edge_cnt_reg >= tempo) begin
                                if (step_idx < pattern_len) begin
                                    step_idx  <= step_idx + 4'd1;
                                    state_reg <= FETCH;
                                end else if (loop_en) begin
                                    step_idx  <= '0;
                                    state_reg <= FETCH;
                                end else begin
                                    done      <= 1'b1;
                                    busy      <= 1'b0;
                                    state_reg <= IDLE;
                                end
                            end else begin
                                edge_cnt_reg <= edge_cnt_reg + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_noise_note_sequencer.sv
// Randomised bench for noise_note_sequencer: a timeline model predicts every
// trigger/done event by clock-edge number and a monitor checks them as they occur.
module tb_noise_note_sequencer;
    localparam int TD = 4;
    localparam int K_BUSY = 0, K_TRIG = 1, K_REST = 2, K_DONE = 3, K_STOPPED = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [3:0]  pattern_len = '0;
    logic [2:0]  tempo = '0;
    logic        note_clk, note_rst, busy, done;
    logic [5:0]  note_in;
    logic [2:0]  note_length;
    logic [1:0]  env_atk, env_dec, fx_sel;
    logic [3:0]  step_idx;

    noise_note_sequencer #(.TICK_DIV(TD)) dut (
        .clk50mhz(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .loop_en(loop_en), .pattern_len(pattern_len),
        .tempo(tempo), .note_clk(note_clk), .note_rst(note_rst), .note_in(note_in),
        .note_length(note_length), .env_atk(env_atk), .env_dec(env_dec), .fx_sel(fx_sel),
        .busy(busy), .step_idx(step_idx), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          edge_at;
        int          idx;
        logic [15:0] w;
    } ev_t;

    ev_t         sb[$];
    ev_t         ev;
    logic [15:0] mem_model [16];
    int          edge_no = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    // Edges counted from reset release; edge 1 is the first posedge after it.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_no <= 0;
        else     edge_no <= edge_no + 1;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, edge_no);
        end
    endtask

    task automatic check_fields(input ev_t e);
        check("step_idx", int'(step_idx), e.idx);
        check("note_in", int'(note_in), int'(e.w[5:0]));
        check("note_length", int'(note_length), int'(e.w[8:6]));
        check("fx_sel", int'(fx_sel), int'(e.w[10:9]));
        check("env_atk", int'(env_atk), int'(e.w[12:11]));
        check("env_dec", int'(env_dec), int'(e.w[14:13]));
    endtask

    // Monitor: pops every event due at the current edge and compares.
    always @(negedge clk) begin
        automatic bit trig_exp = 1'b0;
        automatic bit done_exp = 1'b0;
        if (!rst) begin
            check("note_clk", int'(note_clk), (edge_no / TD) % 2);
            while (sb.size() > 0 && sb[0].edge_at <= edge_no) begin
                ev = sb.pop_front();
                check("event_edge", edge_no, ev.edge_at);
                case (ev.kind)
                    K_BUSY: check("busy_after_start", int'(busy), 1);
                    K_TRIG: begin
                        trig_exp = 1'b1;
                        check("busy_trig", int'(busy), 1);
                        check_fields(ev);
                    end
                    K_REST: begin
                        check("busy_rest", int'(busy), 1);
                        check_fields(ev);
                    end
                    K_DONE: begin
                        done_exp = 1'b1;
                        check("busy_at_done", int'(busy), 0);
                        check("step_idx_done", int'(step_idx), ev.idx);
                    end
                    default: begin
                        check("busy_stopped", int'(busy), 0);
                        check_fields(ev);
                    end
                endcase
            end
            check("note_rst", int'(note_rst), int'(trig_exp));
            check("done", int'(done), int'(done_exp));
        end
    end

    function automatic int next_rise(input int x);
        int r;
        r = x % (2 * TD);
        return (r <= TD) ? x + (TD - r) : x + (3 * TD - r);
    endfunction

    task automatic push(input int k, input int e, input int i, input logic [15:0] w);
        sb.push_back('{k, e, i, w});
    endtask

    // Timeline model: FETCH at s, TRIGGER at s+1, outputs after s+2; a step ends on
    // its (tempo+1)th note_clk rise seen while playing; reads see only earlier writes.
    task automatic plan_run(input int s, input int plen, input bit lp, input int tmp,
                            input int max_steps, input bit pw_en, input int pw_addr,
                            input logic [15:0] pw_data, input int pw_step,
                            output int end_edge, output int pw_edge);
        int t, idx, e, n;
        logic [15:0] w;
        push(K_BUSY, s, 0, '0);
        t = s + 2; idx = 0; n = 0; pw_edge = -1; end_edge = -1;
        forever begin
            if (pw_en && n == pw_step) pw_edge = t - 1;
            w = (pw_en && pw_edge >= 0 && pw_edge < t - 1 && pw_addr == idx) ? pw_data : mem_model[idx];
            push(w[15] ? K_REST : K_TRIG, t, idx, w);
            n++;
            if (lp && n == max_steps) begin
                push(K_STOPPED, t + 1, idx, w);
                push(K_STOPPED, t + 2, idx, w);
                end_edge = t + 1;
                return;
            end
            e = next_rise(t + 1) + tmp * 2 * TD;
            if (idx < plen) idx++;
            else if (lp) idx = 0;
            else begin
                push(K_DONE, e, idx, w);
                end_edge = e;
                return;
            end
            t = e + 2;
        end
    endtask

    task automatic wait_edge(input int e);
        int guard = 0;
        while (edge_no < e && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_no < e) check("wait_timeout", edge_no, e);
    endtask

    task automatic write_word(input int a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        mem_model[a] = d;
    endtask

    task automatic check_all_zero();
        check("rst_note_clk", int'(note_clk), 0);
        check("rst_note_rst", int'(note_rst), 0);
        check("rst_note_in", int'(note_in), 0);
        check("rst_note_length", int'(note_length), 0);
        check("rst_env_atk", int'(env_atk), 0);
        check("rst_env_dec", int'(env_dec), 0);
        check("rst_fx_sel", int'(fx_sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_step_idx", int'(step_idx), 0);
        check("rst_done", int'(done), 0);
    endtask

    task automatic run_pattern(input int plen, input bit lp, input int tmp, input int max_steps,
                               input bit stray, input bit pw_en, input int pw_addr,
                               input logic [15:0] pw_data, input int pw_step,
                               input bit stop_with_start, input int abort_at);
        int s, end_edge, pw_edge;
        loop_en = lp; pattern_len = 4'(plen); tempo = 3'(tmp);
        s = edge_no + 1;
        plan_run(s, plen, lp, tmp, max_steps, pw_en, pw_addr, pw_data, pw_step, end_edge, pw_edge);
        $display("run: start@%0d len=%0d loop=%0d tempo=%0d end@%0d", s, plen, lp, tmp, end_edge);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (abort_at > 0) begin
            wait_edge(s + abort_at);
            #2 rst = 1'b1;
            #1 check_all_zero();
            sb.delete();
            @(negedge clk);
            #2 rst = 1'b0;
            @(negedge clk);
            return;
        end
        if (stray) begin
            wait_edge(s + 2);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (pw_en) begin
            wait_edge(pw_edge - 1);
            write_word(pw_addr, pw_data);
        end
        if (lp) begin
            wait_edge(end_edge - 1);
            stop = 1'b1; start = stop_with_start;
            @(negedge clk);
            stop = 1'b0; start = 1'b0;
        end
        wait_edge(end_edge + 3);
    endtask

    initial begin
        logic [15:0] w;
        repeat (3) @(negedge clk);
        check_all_zero();
        #2 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) write_word(i, 16'($urandom));

        // Single step: note 0x15, length 3, fx 1, attack 2, decay 1.
        w = {1'b0, 2'd1, 2'd2, 2'd1, 3'd3, 6'h15};
        write_word(0, w);
        run_pattern(0, 1'b0, 1, 0, 1'b0, 1'b0, 0, '0, 0, 1'b0, 0);

        // Randomised one-shot patterns, some with an ignored start while busy.
        for (int r = 0; r < 8; r++) begin
            int plen;
            plen = $urandom_range(0, 5);
            for (int i = 0; i <= plen; i++) begin
                w = 16'($urandom);
                w[15] = ($urandom_range(0, 3) == 0);
                write_word(i, w);
            end
            run_pattern(plen, 1'b0, $urandom_range(0, 7), 0, r[0], 1'b0, 0, '0, 0, 1'b0, 0);
        end

        // Loop with a rest step, stopped together with start, then plain restart.
        for (int i = 0; i < 3; i++) begin
            w = 16'($urandom);
            w[5:0] = 6'(i + 1);
            w[15] = (i == 1);
            write_word(i, w);
        end
        run_pattern(2, 1'b1, 0, 7, 1'b0, 1'b0, 0, '0, 0, 1'b1, 0);
        run_pattern(2, 1'b0, 0, 0, 1'b0, 1'b0, 0, '0, 0, 1'b0, 0);

        // Write collision: step 1 rewritten on the very edge it is fetched.
        w = 16'($urandom);
        w[15] = 1'b0;
        w[5:0] = ~mem_model[1][5:0];
        run_pattern(1, 1'b1, $urandom_range(0, 3), 4, 1'b0, 1'b1, 1, w, 1, 1'b0, 0);

        // Asynchronous reset in the middle of a step, then a replay from intact RAM.
        run_pattern(3, 1'b0, 3, 0, 1'b0, 1'b0, 0, '0, 0, 1'b0, 7);
        run_pattern(3, 1'b0, 1, 0, 1'b0, 1'b0, 0, '0, 0, 1'b0, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
